e3_serial_rx: RTL and testbench
===============================

Name: e3_serial_rx

Overview:
- Upstream stage of the Excess-3 to BCD converter.
- Receives Excess-3 digits as a serial bit stream, LSB first, and assembles them into 4-bit codes.
- Rejects codes outside the Excess-3 range and buffers valid digits in a small FIFO.
- Presents one digit at a time to the converter's 4-bit input through a valid/ready handshake.

Parameters:
- DEPTH, 4, FIFO depth in digits; must be a power of 2 and at least 2.
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- sin  input  1  serial data bit.
- sin_vld  input  1  sin is sampled on this edge.
- sin_sof  input  1  qualified by sin_vld; marks bit 0 (the LSB) of a new digit.
- d  output  4  Excess-3 digit at the FIFO head; feeds the converter input.
- d_vld  output  1  FIFO not empty.
- d_rdy  input  1  downstream accepts d; a pop occurs when d_vld&d_rdy.
- err  output  1  one-cycle pulse: invalid code or misaligned frame.
- err_cnt  output  CNT_W  count of err events, saturating.
- ovf  output  1  one-cycle pulse: valid digit dropped because the FIFO was full.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: the following are all 0:
  - d, d_vld, err, err_cnt, ovf, level;
  - bit counter, shift register, FIFO pointers.
- Reset is honoured mid-digit and mid-handshake. A partial digit and all FIFO contents are lost.
- Bit assembly:
  - A 2-bit counter bc tracks the next bit position. Bit k of the digit is written to shreg[k].
  - Only edges with sin_vld=1 are considered; sin_sof and sin are ignored when sin_vld=0.
- sin_vld & sin_sof:
  - sin is written as bit 0 and bc becomes 1.
  - If bc was nonzero, the partial digit is discarded, err pulses the next cycle, and err_cnt increments.
- sin_vld & !sin_sof: the bit is written at position bc and bc increments.
- Fourth bit (bc==3 with sin_vld & !sin_sof):
  - The digit completes on that edge and bc wraps to 0.
  - The code is {sin, shreg[2:0]}. It is valid when it lies in 4'b0011..4'b1100, i.e. decimal 0..9.
- Valid code handling:
  - A valid code is pushed into the FIFO on the same edge.
  - If the FIFO was empty, d_vld rises and d shows the code in the cycle right after that edge, giving 1-cycle latency from the last bit.
- Invalid code (0000, 0001, 0010, 1101, 1110, 1111):
  - The code is not pushed.
  - err pulses high for exactly one cycle after the edge, and err_cnt increments.
- err_cnt stops at 2^CNT_W-1 and never wraps.
- FIFO:
  - d is always mem[rd_ptr], with no register stage on the read path.
  - Pointers wrap modulo DEPTH.
  - level goes up by 1 on a push alone, down by 1 on a pop alone, and is unchanged on a simultaneous push and pop.
- Full FIFO (level==DEPTH):
  - If a pop happens on the same edge, the push is accepted and level stays DEPTH.
  - Otherwise the digit is dropped and ovf pulses for one cycle. ovf does not increment err_cnt.
- Empty FIFO: d_vld=0. A d_rdy asserted while empty has no effect.
- Handshake rule: while d_vld=1 and d_rdy=0, d must stay stable.
- err and ovf cannot both fire for the same digit. Both are registered pulses.

Test Plan:
- Reset behaviour: reset, then send bits 1,1,0,0 (code 0011), with sof on the first bit → d_vld=1 and d=4'b0011 one cycle after the 4th bit; level=1. d_rdy=1 → level=0 and d_vld=0 next cycle.
- Back-to-back streaming: send 0011, 0101, 1100 back-to-back with d_rdy=0 → level=3. Raise d_rdy → d shows 0011, then 0101, then 1100 in consecutive cycles; err=0 throughout.
- Invalid codes: send 1101, then 0000 → two err pulses, err_cnt=2, level=0. Then send 1001 → accepted, d=1001.
- Misaligned frame: send 2 bits, then assert sof with a new full digit 0110 → one err pulse and err_cnt=1 at the sof edge; d=0110 is delivered.
- Overflow: with DEPTH=4 and d_rdy=0, send 5 valid digits → level=4 and one ovf pulse on the 5th; the first 4 digits are delivered in order. Repeat with d_rdy=1 on the 5th completion edge → no ovf and level stays 4.
- Stalls, saturation and reset: insert sin_vld=0 gaps mid-digit → assembly unaffected. Force 300 invalid codes with CNT_W=8 → err_cnt=255. Assert rst after 2 bits → all outputs 0; the next digit assembles correctly from sof.

Source files
------------

// File: rtl/e3_serial_rx.sv
// ---------------------------------------------------------------------------
// e3_serial_rx
// Serial front end of the Excess-3 to BCD converter. Collects LSB-first
// serial bits into 4-bit Excess-3 codes, rejects codes outside 0011..1100,
// and queues the good digits in a small FIFO that drains through a
// valid/ready handshake.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   sin      serial data bit
//   sin_vld  sin/sin_sof are sampled on this edge
//   sin_sof  marks bit 0 of a new digit (qualified by sin_vld)
//   d        Excess-3 digit at the FIFO head
//   d_vld    FIFO not empty
//   d_rdy    downstream accepts d; pop on d_vld & d_rdy
//   err      one-cycle pulse: invalid code or misaligned frame
//   err_cnt  saturating count of err events
//   ovf      one-cycle pulse: valid digit dropped, FIFO full
//   level    FIFO occupancy
// ---------------------------------------------------------------------------
module e3_serial_rx #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sin,
    input  logic                     sin_vld,
    input  logic                     sin_sof,
    output logic [3:0]               d,
    output logic                     d_vld,
    input  logic                     d_rdy,
    output logic                     err,
    output logic [CNT_W-1:0]         err_cnt,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [1:0]       bc_q, bc_d;
    logic [2:0]       shreg_q, shreg_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             err_q, err_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [3:0]       mem_q [DEPTH];

    logic [3:0] code;
    logic       complete;
    logic       code_ok;
    logic       misalign;
    logic       full;
    logic       pop;
    logic       push;

    always_comb begin
        // The fourth bit is taken straight from sin, so only bits 0..2 are stored.
        code     = {sin, shreg_q};
        complete = sin_vld && !sin_sof && (bc_q == 2'd3);
        code_ok  = (code >= 4'd3) && (code <= 4'd12);
        misalign = sin_vld && sin_sof && (bc_q != 2'd0);
        full     = (level_q == LW'(DEPTH));
        pop      = (level_q != '0) && d_rdy;
        // A full FIFO still takes the digit when the head leaves on the same edge.
        push     = complete && code_ok && (!full || pop);
        ovf_d    = complete && code_ok && full && !pop;
        err_d    = misalign || (complete && !code_ok);

        bc_d    = bc_q;
        shreg_d = shreg_q;
        if (sin_vld) begin
            if (sin_sof) begin
                shreg_d[0] = sin;
                bc_d       = 2'd1;
            end else begin
                if (bc_q != 2'd3) begin
                    shreg_d[bc_q] = sin;
                end
                bc_d = bc_q + 2'd1;
            end
        end

        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc_q      <= '0;
            shreg_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            bc_q      <= bc_d;
            shreg_q   <= shreg_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage entries are cleared on reset so that d reads 0 out of reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_q[gi] <= '0;
                end else if (push && (wr_ptr_q == PW'(gi))) begin
                    mem_q[gi] <= code;
                end
            end
        end
    endgenerate

    assign d       = mem_q[rd_ptr_q];
    assign d_vld   = (level_q != '0);
    assign err     = err_q;
    assign ovf     = ovf_q;
    assign err_cnt = err_cnt_q;
    assign level   = level_q;

endmodule

// File: tb/tb_e3_serial_rx.sv
module tb_e3_serial_rx;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sin = 1'b0;
    logic             sin_vld = 1'b0;
    logic             sin_sof = 1'b0;
    logic [3:0]       d;
    logic             d_vld;
    logic             d_rdy = 1'b0;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic             ovf;
    logic [$clog2(DEPTH):0] level;

    e3_serial_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sin_sof(sin_sof),
        .d(d), .d_vld(d_vld), .d_rdy(d_rdy), .err(err), .err_cnt(err_cnt),
        .ovf(ovf), .level(level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: digits as integers, FIFO as a queue.
    logic [3:0] m_q[$];
    logic [3:0] exp_pops[$];
    logic [3:0] obs_pops[$];
    int m_pos = 0;
    int m_bits = 0;
    int m_err_cnt = 0;
    int m_err_ev = 0;
    int m_ovf_ev = 0;
    int obs_err_ev = 0;
    int obs_ovf_ev = 0;

    task automatic clear_obs();
        exp_pops.delete();
        obs_pops.delete();
        m_err_ev = 0;
        m_ovf_ev = 0;
        obs_err_ev = 0;
        obs_ovf_ev = 0;
    endtask

    // One clock edge: drive inputs, advance the model, sample after the edge.
    task automatic step(input logic s, input logic v, input logic f, input logic r);
        bit popm;
        bit pushm;
        bit fullm;
        bit errm;
        sin = s; sin_vld = v; sin_sof = f; d_rdy = r;
        if (d_vld === 1'b1 && r) obs_pops.push_back(d);
        popm  = (m_q.size() != 0) && r;
        fullm = (m_q.size() == DEPTH);
        pushm = 0;
        errm  = 0;
        if (popm) exp_pops.push_back(m_q[0]);
        if (v) begin
            if (f) begin
                if (m_pos != 0) errm = 1;
                m_bits = int'(s);
                m_pos = 1;
            end else begin
                if (m_pos == 0) m_bits = 0;
                m_bits = m_bits + (int'(s) << m_pos);
                m_pos++;
                if (m_pos == 4) begin
                    m_pos = 0;
                    if (m_bits >= 3 && m_bits <= 12) begin
                        if (fullm && !popm) m_ovf_ev++;
                        else pushm = 1;
                    end else begin
                        errm = 1;
                    end
                end
            end
        end
        if (errm) begin
            m_err_ev++;
            if (m_err_cnt < CMAX) m_err_cnt++;
        end
        if (popm) void'(m_q.pop_front());
        if (pushm) m_q.push_back(m_bits[3:0]);
        @(posedge clk);
        #1;
        obs_err_ev += int'(err);
        obs_ovf_ev += int'(ovf);
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) step(1'b0, 1'b0, 1'b0, r);
    endtask

    // Sends a 4-bit code LSB first with sof on bit 0; optional random stall cycles.
    task automatic send_digit(input logic [3:0] c, input logic r_mid, input logic r_last, input int gap_max);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, gap_max)) step(1'($urandom), 1'b0, 1'($urandom), r_mid);
            step(c[k], 1'b1, (k == 0), (k == 3) ? r_last : r_mid);
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        m_q.delete();
        m_pos = 0;
        m_bits = 0;
        m_err_cnt = 0;
        clear_obs();
        #3;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        sin = 1'b0; sin_vld = 1'b0; sin_sof = 1'b0; d_rdy = 1'b0;
    endtask

    function automatic logic [3:0] rand_valid();
        return 4'($urandom_range(3, 12));
    endfunction

    function automatic logic [3:0] rand_invalid();
        int r;
        r = $urandom_range(0, 5);
        return (r < 3) ? 4'(r) : 4'(r + 10);
    endfunction

    task automatic test_reset();
        do_reset();
        n_checks++; if (d !== 4'd0)       begin n_fail++; $display("FAIL reset_d: got %h want 0", d); end
        n_checks++; if (d_vld !== 1'b0)   begin n_fail++; $display("FAIL reset_dvld: got %b want 0", d_vld); end
        n_checks++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (err_cnt !== '0)   begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
        n_checks++; if (ovf !== 1'b0)     begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        n_checks++; if (level !== '0)     begin n_fail++; $display("FAIL reset_level: got %0d want 0", level); end
        release_reset();
        send_digit(4'b0011, 1'b0, 1'b0, 0);
        n_checks++; if (d_vld !== 1'b1)   begin n_fail++; $display("FAIL first_dvld: got %b want 1", d_vld); end
        n_checks++; if (d !== 4'b0011)    begin n_fail++; $display("FAIL first_d: got %b want 0011", d); end
        n_checks++; if (level !== 3'd1)   begin n_fail++; $display("FAIL first_level: got %0d want 1", level); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (level !== 3'd0)   begin n_fail++; $display("FAIL pop_level: got %0d want 0", level); end
        n_checks++; if (d_vld !== 1'b0)   begin n_fail++; $display("FAIL pop_dvld: got %b want 0", d_vld); end
        $display("test_reset: popped %0d digit(s)", obs_pops.size());
    endtask

    task automatic test_back_to_back();
        logic [3:0] want [3];
        want[0] = 4'b0011; want[1] = 4'b0101; want[2] = 4'b1100;
        do_reset();
        release_reset();
        for (int i = 0; i < 3; i++) send_digit(want[i], 1'b0, 1'b0, 0);
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL b2b_level: got %0d want 3", level); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (d !== want[i]) begin n_fail++; $display("FAIL b2b_d%0d: got %b want %b", i, d, want[i]); end
            step(1'b0, 1'b0, 1'b0, 1'b1);
        end
        n_checks++; if (d_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b want 0", d_vld); end
        n_checks++; if (obs_err_ev !== 0) begin n_fail++; $display("FAIL b2b_err: got %0d pulses want 0", obs_err_ev); end
        $display("test_back_to_back: drained %0d digits", obs_pops.size());
    endtask

    task automatic test_invalid();
        do_reset();
        release_reset();
        send_digit(4'b1101, 1'b0, 1'b0, 0);
        send_digit(4'b0000, 1'b0, 1'b0, 0);
        idle(1, 1'b0);
        n_checks++; if (obs_err_ev !== 2) begin n_fail++; $display("FAIL inv_pulses: got %0d want 2", obs_err_ev); end
        n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL inv_errcnt: got %0d want 2", err_cnt); end
        n_checks++; if (level !== 3'd0)   begin n_fail++; $display("FAIL inv_level: got %0d want 0", level); end
        send_digit(4'b1001, 1'b0, 1'b0, 0);
        n_checks++; if (d !== 4'b1001 || d_vld !== 1'b1) begin n_fail++; $display("FAIL inv_accept: got d=%b vld=%b want 1001/1", d, d_vld); end
        idle(2, 1'b1);
        $display("test_invalid: err_cnt=%0d", err_cnt);
    endtask

    task automatic test_misalign();
        do_reset();
        release_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);   // sof arrives early: bit 0 of 0110
        n_checks++; if (err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL mis_err: got err=%b cnt=%0d want 1/1", err, err_cnt); end
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (d !== 4'b0110 || d_vld !== 1'b1) begin n_fail++; $display("FAIL mis_d: got d=%b vld=%b want 0110/1", d, d_vld); end
        n_checks++; if (obs_err_ev !== 1) begin n_fail++; $display("FAIL mis_pulses: got %0d want 1", obs_err_ev); end
        idle(2, 1'b1);
        $display("test_misalign: err_cnt=%0d", err_cnt);
    endtask

    task automatic test_overflow();
        logic [3:0] c [5];
        do_reset();
        release_reset();
        for (int i = 0; i < 5; i++) c[i] = rand_valid();
        for (int i = 0; i < 5; i++) send_digit(c[i], 1'b0, 1'b0, 0);
        n_checks++; if (level !== 3'd4)   begin n_fail++; $display("FAIL ovf_level: got %0d want 4", level); end
        n_checks++; if (obs_ovf_ev !== 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d want 1", obs_ovf_ev); end
        n_checks++; if (err_cnt !== '0)   begin n_fail++; $display("FAIL ovf_errcnt: got %0d want 0", err_cnt); end
        idle(DEPTH + 1, 1'b1);
        n_checks++; if (obs_pops.size() !== 4) begin n_fail++; $display("FAIL ovf_npop: got %0d want 4", obs_pops.size()); end
        for (int i = 0; i < 4 && i < obs_pops.size(); i++) begin
            n_checks++; if (obs_pops[i] !== c[i]) begin n_fail++; $display("FAIL ovf_order%0d: got %b want %b", i, obs_pops[i], c[i]); end
        end
        clear_obs();
        for (int i = 0; i < 5; i++) c[i] = rand_valid();
        for (int i = 0; i < 4; i++) send_digit(c[i], 1'b0, 1'b0, 0);
        send_digit(c[4], 1'b0, 1'b1, 0);
        n_checks++; if (level !== 3'd4)   begin n_fail++; $display("FAIL ovfpop_level: got %0d want 4", level); end
        n_checks++; if (obs_ovf_ev !== 0) begin n_fail++; $display("FAIL ovfpop_pulses: got %0d want 0", obs_ovf_ev); end
        idle(DEPTH + 1, 1'b1);
        n_checks++; if (obs_pops.size() !== 5) begin n_fail++; $display("FAIL ovfpop_npop: got %0d want 5", obs_pops.size()); end
        for (int i = 0; i < 5 && i < obs_pops.size(); i++) begin
            n_checks++; if (obs_pops[i] !== c[i]) begin n_fail++; $display("FAIL ovfpop_order%0d: got %b want %b", i, obs_pops[i], c[i]); end
        end
        $display("test_overflow: second pass drained %0d digits", obs_pops.size());
    endtask

    // Random codes, stalls, early sof and random back-pressure against the model.
    task automatic test_random();
        do_reset();
        release_reset();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'($urandom), 1'b1, 1'b0, 1'($urandom));
            end
            send_digit(($urandom_range(0, 3) == 0) ? rand_invalid() : rand_valid(),
                       1'($urandom), 1'($urandom), 2);
            n_checks++; if (level !== 3'(m_q.size())) begin n_fail++; $display("FAIL rnd_level%0d: got %0d want %0d", i, level, m_q.size()); end
        end
        idle(DEPTH + 2, 1'b1);
        n_checks++; if (err_cnt !== 8'(m_err_cnt)) begin n_fail++; $display("FAIL rnd_errcnt: got %0d want %0d", err_cnt, m_err_cnt); end
        n_checks++; if (obs_err_ev !== m_err_ev) begin n_fail++; $display("FAIL rnd_errpulses: got %0d want %0d", obs_err_ev, m_err_ev); end
        n_checks++; if (obs_ovf_ev !== m_ovf_ev) begin n_fail++; $display("FAIL rnd_ovfpulses: got %0d want %0d", obs_ovf_ev, m_ovf_ev); end
        n_checks++; if (obs_pops.size() !== exp_pops.size()) begin n_fail++; $display("FAIL rnd_npop: got %0d want %0d", obs_pops.size(), exp_pops.size()); end
        for (int i = 0; i < exp_pops.size() && i < obs_pops.size(); i++) begin
            n_checks++; if (obs_pops[i] !== exp_pops[i]) begin n_fail++; $display("FAIL rnd_pop%0d: got %b want %b", i, obs_pops[i], exp_pops[i]); end
        end
        $display("test_random: %0d digits delivered, %0d err, %0d ovf", obs_pops.size(), obs_err_ev, obs_ovf_ev);
    endtask

    task automatic test_saturation();
        do_reset();
        release_reset();
        for (int i = 0; i < 300; i++) send_digit(rand_invalid(), 1'b0, 1'b0, 0);
        idle(1, 1'b0);
        n_checks++; if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_errcnt: got %0d want 255", err_cnt); end
        n_checks++; if (obs_err_ev !== 300) begin n_fail++; $display("FAIL sat_pulses: got %0d want 300", obs_err_ev); end
        n_checks++; if (level !== 3'd0)     begin n_fail++; $display("FAIL sat_level: got %0d want 0", level); end
        $display("test_saturation: err_cnt=%0d after %0d pulses", err_cnt, obs_err_ev);
    endtask

    task automatic test_reset_mid();
        logic [3:0] c;
        send_digit(rand_valid(), 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        n_checks++; if (d !== 4'd0 || d_vld !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL mid_rst_fifo: got d=%b vld=%b lvl=%0d want 0/0/0", d, d_vld, level); end
        n_checks++; if (err !== 1'b0 || ovf !== 1'b0 || err_cnt !== '0) begin n_fail++; $display("FAIL mid_rst_flags: got err=%b ovf=%b cnt=%0d want 0/0/0", err, ovf, err_cnt); end
        release_reset();
        c = rand_valid();
        send_digit(c, 1'b0, 1'b0, 0);
        n_checks++; if (d !== c || d_vld !== 1'b1) begin n_fail++; $display("FAIL mid_rst_next: got d=%b vld=%b want %b/1", d, d_vld, c); end
        n_checks++; if (obs_err_ev !== 0) begin n_fail++; $display("FAIL mid_rst_err: got %0d pulses want 0", obs_err_ev); end
        $display("test_reset_mid: digit %b after reset", d);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_invalid();
        test_misalign();
        test_overflow();
        test_random();
        test_saturation();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
